cdb_arbiter: RTL and testbench

Schedules the common data bus (CDB) between the execute-stage functional units of the R10K core. Each cycle it picks up to `N_CDB` completing results from `N_FU` requesters using rotating priority. It registers the winners onto the CDB lanes that feed ROB completion, RS wakeup and the physical register file write port. Losing units are stalled until they win, and a branch squash cancels everything in flight.

---
 rtl/cdb_arbiter.sv | 89 ++++++++
 tb/tb_cdb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: rotating-priority selection of up to N_CDB completing
// functional-unit results per cycle, registered onto the CDB lanes.
module cdb_arbiter #(
  parameter int N_FU  = 6,
  parameter int N_CDB = 2,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32,
  localparam int PTR_W = $clog2(N_FU),
  localparam int CNT_W = $clog2(N_CDB) + 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [N_FU-1:0]                  fu_req,
  input  logic [N_FU-1:0][TAG_W-1:0]       fu_tag,
  input  logic [N_FU-1:0][XLEN-1:0]        fu_data,
  output logic [N_FU-1:0]                  fu_gnt,
  output logic [N_CDB-1:0]                 cdb_valid,
  output logic [N_CDB-1:0][TAG_W-1:0]      cdb_tag,
  output logic [N_CDB-1:0][XLEN-1:0]       cdb_data,
  output logic [CNT_W-1:0]                 cdb_count
);

  // Handshake: fu_req is a valid that must stay asserted with stable tag/data
  // until fu_gnt is seen high in the same cycle; the result transfers on that edge.

  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                next_ptr;
  logic [CNT_W-1:0]                used;
  logic [N_CDB-1:0]                nxt_valid;
  logic [N_CDB-1:0][TAG_W-1:0]     nxt_tag;
  logic [N_CDB-1:0][XLEN-1:0]      nxt_data;
  logic [PTR_W:0]                  idx_sum;
  logic [PTR_W-1:0]                idx;

  always_comb begin
    fu_gnt    = '0;
    used      = '0;
    next_ptr  = rr_ptr;
    nxt_valid = '0;
    nxt_tag   = '0;
    nxt_data  = '0;
    idx_sum   = '0;
    idx       = '0;
    if (!reset && !squash) begin
      for (int k = 0; k < N_FU; k++) begin
        idx_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (idx_sum >= (PTR_W+1)'(N_FU))
          idx_sum = idx_sum - (PTR_W+1)'(N_FU);
        idx = idx_sum[PTR_W-1:0];
        if (fu_req[idx]) begin
          // Zero-tag results have no destination: retire freely, no lane, no pointer move.
          if (fu_tag[idx] == '0) begin
            fu_gnt[idx] = 1'b1;
          end else if (used < CNT_W'(N_CDB)) begin
            fu_gnt[idx] = 1'b1;
            for (int l = 0; l < N_CDB; l++) begin
              if (used == CNT_W'(l)) begin
                nxt_valid[l] = 1'b1;
                nxt_tag[l]   = fu_tag[idx];
                nxt_data[l]  = fu_data[idx];
              end
            end
            used     = used + CNT_W'(1);
            next_ptr = (idx == PTR_W'(N_FU - 1)) ? '0 : idx + PTR_W'(1);
          end
        end
      end
    end
  end

  // Under squash the combinational block already yields empty lanes and a held pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_count <= '0;
    end else begin
      rr_ptr    <= next_ptr;
      cdb_valid <= nxt_valid;
      cdb_tag   <= nxt_tag;
      cdb_data  <= nxt_data;
      cdb_count <= used;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, full load, wrap-around, zero-tag bypass,
// squash, single requester, and reset+squash together.
module tb_cdb_arbiter;

  localparam int N_FU  = 6;
  localparam int N_CDB = 2;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(N_CDB) + 1;

  logic                         clock;
  logic                         reset;
  logic                         squash;
  logic [N_FU-1:0]              fu_req;
  logic [N_FU-1:0][TAG_W-1:0]   fu_tag;
  logic [N_FU-1:0][XLEN-1:0]    fu_data;
  logic [N_FU-1:0]              fu_gnt;
  logic [N_CDB-1:0]             cdb_valid;
  logic [N_CDB-1:0][TAG_W-1:0]  cdb_tag;
  logic [N_CDB-1:0][XLEN-1:0]   cdb_data;
  logic [CNT_W-1:0]             cdb_count;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.N_FU(N_FU), .N_CDB(N_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_req(fu_req), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_gnt(fu_gnt), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_count(cdb_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] data_of(input logic [TAG_W-1:0] t);
    return 32'hDA7A_0000 | XLEN'(t);
  endfunction

  // driver tasks
  task automatic put(input int i, input logic [TAG_W-1:0] t);
    fu_req[i]  = 1'b1;
    fu_tag[i]  = t;
    fu_data[i] = data_of(t);
  endtask

  task automatic drop(input int i);
    fu_req[i]  = 1'b0;
    fu_tag[i]  = '0;
    fu_data[i] = '0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N_FU; i++) drop(i);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [N_FU-1:0] exp);
    #1;
    chk(tag, 64'(fu_gnt), 64'(exp));
  endtask

  task automatic chk_cdb(input string tag, input logic [N_CDB-1:0] v,
                         input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                         input int cnt, input int ptr);
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    d0 = v[0] ? data_of(t0) : '0;
    d1 = v[1] ? data_of(t1) : '0;
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, ".tag0"},  64'(cdb_tag[0]), 64'(t0));
    chk({tag, ".tag1"},  64'(cdb_tag[1]), 64'(t1));
    chk({tag, ".data0"}, 64'(cdb_data[0]), 64'(d0));
    chk({tag, ".data1"}, 64'(cdb_data[1]), 64'(d1));
    chk({tag, ".count"}, 64'(cdb_count), 64'(cnt));
    chk({tag, ".ptr"},   64'(dut.rr_ptr), 64'(ptr));
  endtask

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    clear_all();
    for (int i = 0; i < N_FU; i++) put(i, TAG_W'(i + 1));

    // reset with all units requesting
    chk_gnt("rst_gnt0", 6'b000000);
    tick();
    chk_gnt("rst_gnt1", 6'b000000);
    tick();
    chk_cdb("rst", 2'b00, 0, 0, 0, 0);

    // full load
    reset = 1'b0;
    chk_gnt("full_g0", 6'b000011);
    tick();
    chk_cdb("full_c1", 2'b11, 1, 2, 2, 2);
    drop(0); drop(1);
    chk_gnt("full_g1", 6'b001100);
    tick();
    chk_cdb("full_c2", 2'b11, 3, 4, 2, 4);
    drop(2); drop(3);
    chk_gnt("full_g2", 6'b110000);
    tick();
    chk_cdb("full_c3", 2'b11, 5, 6, 2, 0);
    drop(4); drop(5);

    // move pointer to 4
    put(2, 1); put(3, 2);
    chk_gnt("pre_g", 6'b001100);
    tick();
    chk_cdb("pre_c", 2'b11, 1, 2, 2, 4);
    drop(2); drop(3);

    // wrap-around
    put(0, 7); put(4, 8); put(5, 9);
    chk_gnt("wrap_g0", 6'b110000);
    tick();
    chk_cdb("wrap_c1", 2'b11, 8, 9, 2, 0);
    drop(4); drop(5);
    chk_gnt("wrap_g1", 6'b000001);
    tick();
    chk_cdb("wrap_c2", 2'b01, 7, 0, 1, 1);
    drop(0);
    chk_gnt("idle_g", 6'b000000);
    tick();
    chk_cdb("idle_c", 2'b00, 0, 0, 0, 1);

    // bring pointer back to 0 through FU5
    put(5, 3);
    chk_gnt("p0_g", 6'b100000);
    tick();
    chk_cdb("p0_c", 2'b01, 3, 0, 1, 0);
    drop(5);

    // zero-tag bypass
    put(1, 0); put(2, 9); put(3, 10);
    chk_gnt("zt_g", 6'b001110);
    tick();
    chk_cdb("zt_c", 2'b11, 9, 10, 2, 4);
    clear_all();

    // squash with valid outputs and FU0-FU2 requesting
    put(0, 11); put(1, 12); put(2, 13);
    squash = 1'b1;
    chk_gnt("sq_g", 6'b000000);
    tick();
    chk_cdb("sq_c", 2'b00, 0, 0, 0, 4);
    squash = 1'b0;
    chk_gnt("sq_res_g0", 6'b000011);
    tick();
    chk_cdb("sq_res_c1", 2'b11, 11, 12, 2, 2);
    drop(0); drop(1);
    chk_gnt("sq_res_g1", 6'b000100);
    tick();
    chk_cdb("sq_res_c2", 2'b01, 13, 0, 1, 3);
    drop(2);

    // single requester, three back-to-back results
    for (int r = 0; r < 3; r++) begin
      put(3, 5);
      chk_gnt($sformatf("single_g%0d", r), 6'b001000);
      tick();
      chk_cdb($sformatf("single_c%0d", r), 2'b01, 5, 0, 1, 4);
    end
    drop(3);

    // reset and squash together mid-operation
    put(0, 1); put(1, 2);
    reset  = 1'b1;
    squash = 1'b1;
    chk_gnt("rsq_g", 6'b000000);
    tick();
    chk_cdb("rsq_c", 2'b00, 0, 0, 0, 0);
    reset  = 1'b0;
    squash = 1'b0;
    chk_gnt("post_rst_g", 6'b000011);
    tick();
    chk_cdb("post_rst_c", 2'b11, 1, 2, 2, 2);
    clear_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
